dcache_wb: RTL and testbench
============================

Name: dcache_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache between the processor MEM stage and main memory.
- Processor side: d_addr, Mem_re, Mem_we, wrt_data, rd_data, d_hit.
- Memory side: whole lines, moved with a level re/we plus mem_rdy completion handshake.
- Hits complete in the request cycle. Misses hold d_hit low (processor stalls) until the line is resident.

Parameters:
- INDEX_BITS, 3, log2 of line count (8 lines).
- OFFSET_BITS, 2, log2 of 16-bit words per line (4 words, 64-bit line).
- ADDR_W, 16, processor word-address width. TAG_W = ADDR_W-INDEX_BITS-OFFSET_BITS = 11.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- d_addr  in  16  word address from EX/MEM register.
- Mem_re  in  1  load request.
- Mem_we  in  1  store request.
- wrt_data  in  16  store data.
- rd_data  out  16  load data, combinational.
- d_hit  out  1  request satisfied this cycle.
- mem_addr  out  14  line address {tag,index} to memory.
- mem_re  out  1  line read request.
- mem_we  out  1  line write request.
- mem_wdata  out  64  line write data.
- mem_rdata  in  64  line read data, valid when mem_rdy.
- mem_rdy  in  1  one-cycle pulse completing the current mem_re/mem_we.

Behaviour:
- Reset (rst=1 at posedge):
  - All valid and dirty bits clear; FSM to IDLE.
  - mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0 registered; d_hit=0 and rd_data=0 while rst is high.
  - Data and tag arrays are not cleared.
- Address split: tag=d_addr[15:5], index=d_addr[4:2], offset=d_addr[1:0].
- Word select: word k = line bits [16k+15:16k].
- hit = valid[index] & (tag_arr[index]==tag).
- IDLE:
  - No request (Mem_re=Mem_we=0): d_hit=1.
  - Request and hit: d_hit=1, same cycle. rd_data = selected word, combinational.
  - Store hit: word written at posedge; dirty[index] set.
  - Miss: d_hit=0, rd_data=0.
    - If valid & dirty: go to WB with mem_addr={tag_arr[index],index}, mem_wdata=line.
    - Otherwise: go to FILL with mem_addr={tag,index}.
    - mem_re/mem_we assert the cycle after the miss is detected.
- WB:
  - mem_we=1; mem_addr and mem_wdata held stable until the cycle mem_rdy=1.
  - On mem_rdy: mem_we drops next cycle; go to FILL (mem_re=1, mem_addr={tag,index}).
- FILL:
  - mem_re=1, held until mem_rdy.
  - On mem_rdy at posedge: line=mem_rdata, tag written, valid=1, dirty=0; go to IDLE.
  - Next cycle re-evaluates; a hit follows.
- Miss latency:
  - Clean miss: d_hit returns high N+2 cycles after the miss cycle, where N = cycles from mem_re to mem_rdy.
  - Dirty miss: adds the writeback time.
- d_hit is 0 in every cycle the FSM is in WB or FILL.
- Simultaneous Mem_re & Mem_we: Mem_we wins; treated as a store.
- Processor holds d_addr/Mem_re/Mem_we/wrt_data stable while d_hit=0.
  - If the address changes mid-miss anyway, the outstanding transfer completes and IDLE re-evaluates the new address; no partial writes.
- mem_rdy outside WB/FILL: ignored.
- Reset mid-operation:
  - Transfer abandoned; mem_re/mem_we low the next cycle.
  - In-flight line discarded; valid clear, so dirty data is lost by design.
- Stores do not update the line during FILL; the store completes as a hit after refill.

Decomposition:
- Package dcache_pkg:
  - State encoding IDLE/WB/FILL (2-bit).
  - TAG_W, LINE_W=64, WORDS_PER_LINE=4.
  - Field-extract functions tag_of, index_of, offset_of.
- Sub-module dcache_array:
  - Holds tag/valid/dirty/data register arrays, combinational read.
  - Write ports: word write, line fill, dirty set, valid/dirty clear on rst.
- dcache_wb contains the FSM and muxing.

Test Plan:
- Cold read after reset: Mem_re, d_addr=16'h0124.
  - d_hit=0; mem_re=1 with mem_addr=14'h0049.
  - mem_rdy after 3 cycles with mem_rdata=64'h4444_3333_2222_1111.
  - d_hit=1 with rd_data=16'h1111 (offset 0).
- Store hit: Mem_we to 16'h0125, wrt_data=16'hBEEF.
  - d_hit=1 same cycle.
  - Following read of 16'h0125 returns 16'hBEEF with no mem_re.
- Dirty conflict: then Mem_re 16'h0924 (same index, tag differs).
  - mem_we=1, mem_addr=14'h0049, mem_wdata=64'h4444_3333_BEEF_1111.
  - Then mem_re with mem_addr=14'h0249; d_hit only after the fill.
- No request: Mem_re=Mem_we=0 in any IDLE cycle -> d_hit=1, mem_re=mem_we=0.
- Reset mid-FILL: assert rst while mem_re=1.
  - Next cycle mem_re=0, FSM IDLE.
  - Re-read of the same address misses again, since valid is cleared.
- Both strobes: Mem_re=Mem_we=1 on a hit -> word written, dirty set, matching a pure store.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared geometry, FSM encoding and address field helpers for the write-back data cache.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dcache_pkg;

   localparam int INDEX_BITS     = 3;
   localparam int OFFSET_BITS    = 2;
   localparam int ADDR_W         = 16;
   localparam int TAG_W          = ADDR_W - INDEX_BITS - OFFSET_BITS;
   localparam int WORD_W         = 16;
   localparam int WORDS_PER_LINE = 1 << OFFSET_BITS;
   localparam int LINE_W         = WORD_W * WORDS_PER_LINE;
   localparam int NUM_LINES      = 1 << INDEX_BITS;
   localparam int MEM_ADDR_W     = TAG_W + INDEX_BITS;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WB   = 2'd1,
      S_FILL = 2'd2
   } state_t;

   function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1 -: TAG_W];
   endfunction

   function automatic logic [INDEX_BITS-1:0] index_of(input logic [ADDR_W-1:0] a);
      return a[OFFSET_BITS +: INDEX_BITS];
   endfunction

   function automatic logic [OFFSET_BITS-1:0] offset_of(input logic [ADDR_W-1:0] a);
      return a[OFFSET_BITS-1:0];
   endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage for the direct-mapped cache, combinational read port.
// Latency: reads same cycle; word writes and line fills take effect at the next posedge.
// Backpressure: none; the controller never issues a word write and a fill together.
module dcache_array
   import dcache_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [INDEX_BITS-1:0]  rd_idx_i,
   output logic [TAG_W-1:0]       rd_tag_o,
   output logic                   rd_valid_o,
   output logic                   rd_dirty_o,
   output logic [LINE_W-1:0]      rd_line_o,
   input  logic                   wr_word_en_i,
   input  logic [INDEX_BITS-1:0]  wr_idx_i,
   input  logic [OFFSET_BITS-1:0] wr_off_i,
   input  logic [WORD_W-1:0]      wr_word_i,
   input  logic                   fill_en_i,
   input  logic [INDEX_BITS-1:0]  fill_idx_i,
   input  logic [TAG_W-1:0]       fill_tag_i,
   input  logic [LINE_W-1:0]      fill_line_i
);

   logic [NUM_LINES-1:0] valid_q;
   logic [NUM_LINES-1:0] dirty_q;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [LINE_W-1:0]    data_q [NUM_LINES];

   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_dirty_o = dirty_q[rd_idx_i];
   assign rd_line_o  = data_q[rd_idx_i];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (fill_en_i) begin
         valid_q[fill_idx_i] <= 1'b1;
         dirty_q[fill_idx_i] <= 1'b0;
      end else if (wr_word_en_i) begin
         dirty_q[wr_idx_i] <= 1'b1;
      end
   end

   // Payload arrays are left uninitialised; valid_q alone gates their use.
   always_ff @(posedge clk) begin
      if (fill_en_i) begin
         tag_q[fill_idx_i]  <= fill_tag_i;
         data_q[fill_idx_i] <= fill_line_i;
      end else if (wr_word_en_i) begin
         data_q[wr_idx_i][wr_off_i*WORD_W +: WORD_W] <= wr_word_i;
      end
   end

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back/write-allocate data cache controller between MEM stage and memory.
// Latency: hits complete in the request cycle; clean miss N+2 cycles, dirty miss adds writeback.
// Backpressure: d_hit low stalls the processor; memory transfers held until mem_rdy pulses.
module dcache_wb
   import dcache_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_W-1:0]     d_addr,
   input  logic                  Mem_re,
   input  logic                  Mem_we,
   input  logic [WORD_W-1:0]     wrt_data,
   output logic [WORD_W-1:0]     rd_data,
   output logic                  d_hit,
   output logic [MEM_ADDR_W-1:0] mem_addr,
   output logic                  mem_re,
   output logic                  mem_we,
   output logic [LINE_W-1:0]     mem_wdata,
   input  logic [LINE_W-1:0]     mem_rdata,
   input  logic                  mem_rdy
);

   state_t                  state_q, state_d;
   logic [MEM_ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic                    mem_re_q, mem_re_d;
   logic                    mem_we_q, mem_we_d;
   logic [LINE_W-1:0]       mem_wdata_q, mem_wdata_d;

   logic [TAG_W-1:0]        req_tag;
   logic [INDEX_BITS-1:0]   req_idx;
   logic [OFFSET_BITS-1:0]  req_off;
   logic [TAG_W-1:0]        arr_tag;
   logic                    arr_valid;
   logic                    arr_dirty;
   logic [LINE_W-1:0]       arr_line;
   logic                    hit;
   logic                    req;
   logic [WORD_W-1:0]       sel_word;
   logic                    wr_word_en;
   logic                    fill_en;

   assign req_tag  = tag_of(d_addr);
   assign req_idx  = index_of(d_addr);
   assign req_off  = offset_of(d_addr);
   assign req      = Mem_re | Mem_we;
   assign hit      = arr_valid & (arr_tag == req_tag);
   assign sel_word = arr_line[req_off*WORD_W +: WORD_W];

   dcache_array u_array (
      .clk          (clk),
      .rst          (rst),
      .rd_idx_i     (req_idx),
      .rd_tag_o     (arr_tag),
      .rd_valid_o   (arr_valid),
      .rd_dirty_o   (arr_dirty),
      .rd_line_o    (arr_line),
      .wr_word_en_i (wr_word_en),
      .wr_idx_i     (req_idx),
      .wr_off_i     (req_off),
      .wr_word_i    (wrt_data),
      .fill_en_i    (fill_en),
      .fill_idx_i   (mem_addr_q[INDEX_BITS-1:0]),
      .fill_tag_i   (mem_addr_q[MEM_ADDR_W-1 -: TAG_W]),
      .fill_line_i  (mem_rdata)
   );

   always_comb begin
      state_d     = state_q;
      mem_addr_d  = mem_addr_q;
      mem_re_d    = mem_re_q;
      mem_we_d    = mem_we_q;
      mem_wdata_d = mem_wdata_q;
      d_hit       = 1'b0;
      rd_data     = '0;
      wr_word_en  = 1'b0;
      fill_en     = 1'b0;
      if (!rst) begin
         case (state_q)
            S_IDLE: begin
               d_hit = ~req | hit;
               if (req && hit) begin
                  rd_data    = sel_word;
                  wr_word_en = Mem_we;
               end else if (req) begin
                  if (arr_valid && arr_dirty) begin
                     state_d     = S_WB;
                     mem_we_d    = 1'b1;
                     mem_addr_d  = {arr_tag, req_idx};
                     mem_wdata_d = arr_line;
                  end else begin
                     state_d    = S_FILL;
                     mem_re_d   = 1'b1;
                     mem_addr_d = {req_tag, req_idx};
                  end
               end
            end
            S_WB: begin
               // Fill target follows the live address so a mid-miss change is honoured.
               if (mem_rdy) begin
                  state_d    = S_FILL;
                  mem_we_d   = 1'b0;
                  mem_re_d   = 1'b1;
                  mem_addr_d = {req_tag, req_idx};
               end
            end
            S_FILL: begin
               if (mem_rdy) begin
                  fill_en  = 1'b1;
                  state_d  = S_IDLE;
                  mem_re_d = 1'b0;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mem_addr_q  <= '0;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         mem_addr_q  <= mem_addr_d;
         mem_re_q    <= mem_re_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_re    = mem_re_q;
   assign mem_we    = mem_we_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb: transfer-queue cache model checked every cycle plus literal pins.
// Latency: memory responder answers each transfer a fixed number of cycles after it appears.
// Backpressure: bench holds requests stable while d_hit is low.
module tb_dcache_wb;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] d_addr;
   logic        Mem_re;
   logic        Mem_we;
   logic [15:0] wrt_data;
   logic [15:0] rd_data;
   logic        d_hit;
   logic [13:0] mem_addr;
   logic        mem_re;
   logic        mem_we;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;
   logic        mem_rdy;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   dcache_wb dut (
      .clk       (clk),
      .rst       (rst),
      .d_addr    (d_addr),
      .Mem_re    (Mem_re),
      .Mem_we    (Mem_we),
      .wrt_data  (wrt_data),
      .rd_data   (rd_data),
      .d_hit     (d_hit),
      .mem_addr  (mem_addr),
      .mem_re    (mem_re),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_rdy   (mem_rdy)
   );

   // Main memory: sparse lines, unwritten lines return an address-derived pattern.
   logic [63:0] mem [logic [13:0]];

   function automatic logic [63:0] mem_rd(input logic [13:0] a);
      if (mem.exists(a)) return mem[a];
      return {4{2'b10, a}};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Memory responder: pulses mem_rdy LAT cycles after a transfer becomes visible.
   localparam int LAT = 3;
   int cnt;
   initial begin
      mem_rdy   = 1'b0;
      mem_rdata = '0;
      cnt       = 0;
      forever begin
         @(posedge clk);
         #2;
         if (rst) begin
            mem_rdy = 1'b0;
            cnt     = 0;
         end else if (mem_rdy) begin
            mem_rdy = 1'b0;
            cnt     = 0;
         end else if (mem_re === 1'b1 || mem_we === 1'b1) begin
            cnt++;
            if (cnt == LAT) begin
               mem_rdy = 1'b1;
               if (mem_we) mem[mem_addr] = mem_wdata;
               else        mem_rdata = mem_rd(mem_addr);
            end
         end
      end
   end

   // Cache model: resident lines plus a queue of memory transfers a miss still owes.
   typedef struct {
      bit          we;
      logic [13:0] addr;
      logic [63:0] wdata;
   } xfer_t;

   xfer_t       q[$];
   bit          m_valid [8];
   bit          m_dirty [8];
   logic [10:0] m_tag   [8];
   logic [63:0] m_line  [8];

   always @(posedge clk) begin
      xfer_t       x;
      logic [2:0]  ix;
      logic [10:0] tg;
      ix = d_addr[4:2];
      tg = d_addr[15:5];
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
         end
         q.delete();
      end else if (q.size() > 0) begin
         if (mem_rdy) begin
            x = q.pop_front();
            if (!x.we) begin
               m_valid[x.addr[2:0]] = 1'b1;
               m_dirty[x.addr[2:0]] = 1'b0;
               m_tag[x.addr[2:0]]   = x.addr[13:3];
               m_line[x.addr[2:0]]  = mem_rd(x.addr);
            end
         end
      end else if (Mem_re || Mem_we) begin
         if (m_valid[ix] && m_tag[ix] == tg) begin
            if (Mem_we) begin
               m_line[ix][d_addr[1:0]*16 +: 16] = wrt_data;
               m_dirty[ix] = 1'b1;
            end
         end else begin
            if (m_valid[ix] && m_dirty[ix]) begin
               x.we = 1'b1; x.addr = {m_tag[ix], ix}; x.wdata = m_line[ix];
               q.push_back(x);
            end
            x.we = 1'b0; x.addr = {tg, ix}; x.wdata = '0;
            q.push_back(x);
         end
      end
   end

   always @(negedge clk) begin
      logic [2:0]  ix;
      logic        req;
      logic        hit;
      if (chk_en) begin
         ix  = d_addr[4:2];
         req = Mem_re | Mem_we;
         hit = m_valid[ix] && (m_tag[ix] == d_addr[15:5]);
         if (q.size() > 0) begin
            chk("bus_re", mem_re, !q[0].we);
            chk("bus_we", mem_we, q[0].we);
            chk("bus_addr", mem_addr, q[0].addr);
            if (q[0].we) chk("bus_wdata", mem_wdata, q[0].wdata);
         end else begin
            chk("bus_re", mem_re, 0);
            chk("bus_we", mem_we, 0);
         end
         if (rst || q.size() > 0) begin
            chk("d_hit", d_hit, 0);
            chk("rd_data", rd_data, 0);
         end else begin
            chk("d_hit", d_hit, !req || hit);
            if (req) chk("rd_data", rd_data, hit ? m_line[ix][d_addr[1:0]*16 +: 16] : 16'h0);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic req_set(input logic re, input logic we, input logic [15:0] a, input logic [15:0] wd);
      Mem_re   = re;
      Mem_we   = we;
      d_addr   = a;
      wrt_data = wd;
   endtask

   task automatic wait_hit(input string name, inout int stall);
      for (int i = 0; i < 40; i++) begin
         step();
         @(negedge clk);
         if (d_hit === 1'b1) return;
         stall++;
      end
      total++;
      bad++;
      $display("FAIL %s: d_hit stayed low, got 0 want 1", name);
   endtask

   task automatic wait_re(input string name);
      for (int i = 0; i < 40; i++) begin
         step();
         @(negedge clk);
         if (mem_re === 1'b1) return;
      end
      total++;
      bad++;
      $display("FAIL %s: mem_re stayed low, got 0 want 1", name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int stall;
      rst = 1'b1;
      req_set(0, 0, 16'h0, 16'h0);
      mem[14'h0049] = 64'h4444_3333_2222_1111;
      mem[14'h0249] = 64'hDDDD_CCCC_BBBB_AAAA;
      mem[14'h00C4] = 64'h8888_7777_6666_5555;

      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_d_hit", d_hit, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_mem_re", mem_re, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);

      // Cold read miss.
      step();
      rst = 1'b0;
      req_set(1, 0, 16'h0124, 16'h0);
      @(negedge clk);
      chk("cold_miss_d_hit", d_hit, 0);
      stall = 1;
      step();
      @(negedge clk);
      chk("cold_mem_re", mem_re, 1);
      chk("cold_mem_addr", mem_addr, 14'h0049);
      stall++;
      wait_hit("cold_fill", stall);
      chk("cold_latency", stall, 4);
      chk("cold_rd_data", rd_data, 16'h1111);

      // Store hit then read-back.
      step();
      req_set(0, 1, 16'h0125, 16'hBEEF);
      @(negedge clk);
      chk("store_hit", d_hit, 1);
      step();
      req_set(1, 0, 16'h0125, 16'h0);
      @(negedge clk);
      chk("readback_hit", d_hit, 1);
      chk("readback_data", rd_data, 16'hBEEF);
      chk("readback_no_mem_re", mem_re, 0);

      // Dirty conflict on index 1.
      step();
      req_set(1, 0, 16'h0924, 16'h0);
      @(negedge clk);
      chk("conflict_d_hit", d_hit, 0);
      step();
      @(negedge clk);
      chk("wb_mem_we", mem_we, 1);
      chk("wb_mem_addr", mem_addr, 14'h0049);
      chk("wb_mem_wdata", mem_wdata, 64'h4444_3333_BEEF_1111);
      wait_re("wb_to_fill");
      chk("fill_mem_addr", mem_addr, 14'h0249);
      chk("fill_d_hit", d_hit, 0);
      stall = 0;
      wait_hit("conflict_fill", stall);
      chk("conflict_rd_data", rd_data, 16'hAAAA);
      chk("wb_landed", mem_rd(14'h0049), 64'h4444_3333_BEEF_1111);

      // Idle cycle.
      step();
      req_set(0, 0, 16'h0924, 16'h0);
      @(negedge clk);
      chk("idle_d_hit", d_hit, 1);
      chk("idle_mem_re", mem_re, 0);
      chk("idle_mem_we", mem_we, 0);

      // Reset while a fill is outstanding.
      step();
      req_set(1, 0, 16'h0310, 16'h0);
      @(negedge clk);
      step();
      @(negedge clk);
      chk("pre_rst_mem_re", mem_re, 1);
      step();
      rst = 1'b1;
      @(negedge clk);
      chk("in_rst_d_hit", d_hit, 0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_abandon_mem_re", mem_re, 0);
      chk("rst_remiss", d_hit, 0);
      stall = 0;
      wait_hit("rst_refill", stall);
      chk("rst_refill_data", rd_data, 16'h5555);
      step();
      req_set(1, 0, 16'h0924, 16'h0);
      @(negedge clk);
      chk("rst_valid_cleared", d_hit, 0);
      stall = 0;
      wait_hit("reload_0924", stall);

      // Both strobes on a hit behave as a store.
      step();
      req_set(1, 1, 16'h0312, 16'h1234);
      @(negedge clk);
      chk("both_hit", d_hit, 1);
      step();
      req_set(1, 0, 16'h0312, 16'h0);
      @(negedge clk);
      chk("both_readback", rd_data, 16'h1234);
      step();
      req_set(1, 0, 16'h0B10, 16'h0);
      @(negedge clk);
      chk("both_conflict", d_hit, 0);
      step();
      @(negedge clk);
      chk("both_wb_we", mem_we, 1);
      chk("both_wb_addr", mem_addr, 14'h00C4);
      chk("both_wb_wdata", mem_wdata, 64'h8888_1234_6666_5555);
      stall = 0;
      wait_hit("both_fill", stall);
      chk("both_wb_landed", mem_rd(14'h00C4), 64'h8888_1234_6666_5555);

      step();
      req_set(0, 0, 16'h0, 16'h0);
      repeat (3) step();
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
